serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor, the sequential stage built directly around the lab's single-bit full adder.
- Accepts two WIDTH-bit operands in parallel and processes one bit per clock, LSB first, through one full_adder instance plus a carry flip-flop.
- Returns a parallel result with carry/borrow and signed overflow.
- Sits between the operand-entry logic (switches/registers) and the result display/compare logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a new operation; sampled on a rising clk edge
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result; held stable until the next accepted start or reset
- cout  output  1  final carry out; for sub, 1 = no borrow (a >= b unsigned)
- overflow  output  1  two's-complement signed overflow of the operation

Behaviour:
- Reset: all registers are cleared when rst_n=0 at a rising edge. State=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, bit counter=0, carry FF=0.
- FSM states:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle.
  - DONE: single cycle; done=1.
- IDLE or DONE with start=1: go to RUN.
  - Load A shift register with a.
  - Load B shift register with b when sub=0, or ~b when sub=1.
  - Carry FF := sub.
  - Counter := 0.
  - Clear sum.
- RUN, each edge:
  - The full adder takes A[0], B[0] and the carry FF.
  - S is shifted into sum from the MSB side (sum := {S, sum[WIDTH-1:1]}).
  - Carry FF := C1.
  - A and B shift right by one.
  - Counter increments.
- RUN with counter == WIDTH-1:
  - Perform the last bit as above.
  - cout := C1.
  - overflow := (carry into MSB) XOR C1, where carry into MSB is the carry FF value at that edge.
  - Go to DONE.
- DONE to IDLE when start=0.
- busy=1 exactly in RUN. done=1 exactly in DONE. Both are registered outputs.
- Latency: start sampled at edge k gives busy high for WIDTH cycles, with done high in the cycle following edge k+WIDTH. Start-to-done is WIDTH+1 cycles.
- start while in RUN is ignored; the operands in flight are unaffected.
- start in the DONE cycle is accepted, allowing back-to-back operations with one dead cycle.
- sum, cout and overflow hold their last result through IDLE.
- While in RUN, sum is partially shifted and has no meaning until done.
- Reset mid-operation (rst_n=0 in RUN): the next state is IDLE with all outputs zero, and no done pulse is produced.
- Counter width: $clog2(WIDTH). No wrap-around because RUN exits at WIDTH-1.

Decomposition:
- Shared header serial_defs.vh holds the state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and the default WIDTH.
- One sub-module: the existing full_adder (ports A, B, C0, S, C1), instantiated once.
- All sequential logic lives in serial_add_sub.

Test Plan (WIDTH=8):
- Reset, then start with a=0x05, b=0x03, sub=0 -> busy high for 8 cycles; done pulses once; sum=0x08, cout=0, overflow=0.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
- a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0 (borrow), overflow=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
- Start a=0x10, b=0x20; pulse start with a=0xAA, b=0x55 in RUN cycle 3 -> second start ignored; sum=0x30. Start again in the done cycle with a=0x01, b=0x01 -> accepted; next result sum=0x02.
- rst_n=0 for one edge in RUN cycle 4 of 0x33+0x44 -> next cycle busy=0, sum=0, cout=0, overflow=0; no done pulse. A following operation runs normally.
- 1000 random a/b/sub operations checked against a behavioural model of {cout,sum} and signed overflow. Also check the done spacing of WIDTH+1 cycles.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding and default width.
package serial_add_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : serial_add_sub_pkg

// File: rtl/full_adder.sv
// Single-bit full adder: S = A ^ B ^ C0, C1 = carry out.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C0,
  output logic S,
  output logic C1
);

  assign S  = A ^ B ^ C0;
  assign C1 = (A & B) | (C0 & (A ^ B));

endmodule : full_adder

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder and carry FF.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;
  logic               r_cout;
  logic               r_ovf;
  logic               w_s;
  logic               w_c1;
  logic               w_last;
  logic               w_load;

  full_adder u_fa (
    .A  (r_a[0]),
    .B  (r_b[0]),
    .C0 (r_carry),
    .S  (w_s),
    .C1 (w_c1)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_load = start && (r_state != S_RUN);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered status flags; B is inverted and carry seeded with 1 for subtraction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
      if (w_load) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
        r_sum   <= '0;
      end else if (r_state == S_RUN) begin
        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
        r_carry <= w_c1;
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_cout <= w_c1;
          r_ovf  <= r_carry ^ w_c1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub (WIDTH=8) against an arithmetic reference model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input int ua, input int ub, input bit s,
                       output int e_sum, output int e_cout, output int e_ovf);
    int sa, sb, sres;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (s) begin
      e_sum  = (ua - ub + 256) % 256;
      e_cout = (ua >= ub) ? 1 : 0;
      sres   = sa - sb;
    end else begin
      e_sum  = (ua + ub) % 256;
      e_cout = (ua + ub > 255) ? 1 : 0;
      sres   = sa + sb;
    end
    e_ovf = (sres > 127 || sres < -128) ? 1 : 0;
  endtask

  // Waits for done (bounded), checking busy on every cycle before it
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < W + 4) begin
      chk("busy_run", 32'(busy), 32'd1);
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic check_result(input string tag, input int ua, input int ub, input bit s);
    int e_sum, e_cout, e_ovf;
    model(ua, ub, s, e_sum, e_cout, e_ovf);
    chk({tag, "_sum"}, 32'(sum), 32'(e_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(e_cout));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e_ovf));
  endtask

  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    a = va; b = vb; sub = vs; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom(); b = $urandom(); sub = $urandom_range(0, 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vs);
    int n;
    launch(va, vb, vs);
    wait_done(n);
    chk({tag, "_latency"}, 32'(n), 32'(W));
    check_result(tag, int'(va), int'(vb), vs);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] held;
    logic [W-1:0] ra, rb;
    logic rs;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick();

    // Directed arithmetic cases
    run_op("add_5_3", 8'h05, 8'h03, 1'b0);
    run_op("add_ff_1", 8'hFF, 8'h01, 1'b0);
    run_op("add_7f_1", 8'h7F, 8'h01, 1'b0);
    chk("add_7f_1_abs_sum", 32'(sum), 32'h80);
    chk("add_7f_1_abs_ovf", 32'(overflow), 32'd1);
    run_op("sub_5_7", 8'h05, 8'h07, 1'b1);
    chk("sub_5_7_abs_sum", 32'(sum), 32'hFE);
    chk("sub_5_7_abs_cout", 32'(cout), 32'd0);
    run_op("sub_80_1", 8'h80, 8'h01, 1'b1);
    chk("sub_80_1_abs_sum", 32'(sum), 32'h7F);
    chk("sub_80_1_abs_cout", 32'(cout), 32'd1);

    // Results hold through IDLE
    held = sum;
    tick(); tick(); tick();
    chk("hold_sum", 32'(sum), 32'(held));
    chk("hold_busy", 32'(busy), 32'd0);

    // Start during RUN is ignored
    launch(8'h10, 8'h20, 1'b0);
    tick(); tick();
    a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ign_latency", 32'(n), 32'(W - 3));
    chk("ign_sum", 32'(sum), 32'h30);

    // Start in DONE cycle accepted
    launch(8'h01, 8'h01, 1'b0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_sum_cleared", 32'(sum), 32'd0);
    wait_done(n);
    chk("b2b_latency", 32'(n), 32'(W));
    chk("b2b_sum", 32'(sum), 32'h02);
    tick();

    // Reset mid-operation
    launch(8'h33, 8'h44, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      chk("mid_rst_no_done", 32'(done), 32'd0);
      tick();
    end
    run_op("post_rst", 8'h33, 8'h44, 1'b0);

    // Random operations, alternating idle gaps and back-to-back starts from DONE
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom());
      rb = W'($urandom());
      rs = 1'($urandom_range(0, 1));
      if (i % 2 == 0) begin
        run_op("rnd", ra, rb, rs);
      end else begin
        launch(ra, rb, rs);
        wait_done(n);
        chk("rnd_latency", 32'(n), 32'(W));
        check_result("rnd", int'(ra), int'(rb), rs);
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_add_sub
